// File: rtl/noc_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// noc_traffic_gen_if
// Flit output channel between a traffic generator and one router input port.
//   odata   : flit, {type, payload}            (generator -> router)
//   ovalid  : flit valid                       (generator -> router)
//   ovch    : virtual channel of the flit      (generator -> router)
//   ordy    : per-VC ready, one bit per VC     (router -> generator)
// A flit moves at a rising edge where ovalid && ordy[ovch].
// ---------------------------------------------------------------------------
interface noc_traffic_gen_if #(
    parameter int PAYW  = 32,
    parameter int TYPEW = 2,
    parameter int VCN   = 4
);
    localparam int VCW = (VCN > 1) ? $clog2(VCN) : 1;

    logic [TYPEW+PAYW-1:0] odata;
    logic                  ovalid;
    logic [VCW-1:0]        ovch;
    logic [VCN-1:0]        ordy;

    modport master (output odata, output ovalid, output ovch, input ordy);
    modport slave  (input odata, input ovalid, input ovch, output ordy);
endinterface

// File: rtl/noc_traffic_gen.sv
// ---------------------------------------------------------------------------
// noc_traffic_gen
// Packet injector for one router input port. Emits wormhole packets
// (HEAD, cfg_len DATA flits, TAIL) on a configurable VC, with a configurable
// idle gap after each TAIL, an optional packet budget and LFSR payloads.
// Ports:
//   clk       : clock, rising edge
//   rst_      : synchronous reset, active-low
//   enable    : start / continue generation
//   cfg_len   : DATA flits per packet
//   cfg_gap   : idle cycles after each TAIL
//   cfg_npkt  : packets to send, 0 = unlimited
//   cfg_dst   : HEAD payload (destination word)
//   cfg_vch   : VC used for the packet
//   bus       : flit channel (odata/ovalid/ovch out, ordy in)
//   busy      : packet in flight or gap counting
//   done      : cfg_npkt packets sent
//   pkt_cnt   : TAILs accepted (wraps)
//   flit_cnt  : flits accepted (wraps)
// Outputs are decoded from registered state only, so a stalled flit cannot
// change until it is accepted.
// ---------------------------------------------------------------------------
module noc_traffic_gen #(
    parameter int              PAYW   = 32,
    parameter int              TYPEW  = 2,
    parameter int              VCN    = 4,
    parameter int              LENW   = 8,
    parameter int              GAPW   = 8,
    parameter int              CNTW   = 32,
    parameter logic [31:0]     SEED   = 32'h1,
    parameter logic [TYPEW-1:0] T_NONE = TYPEW'(0),
    parameter logic [TYPEW-1:0] T_HEAD = TYPEW'(1),
    parameter logic [TYPEW-1:0] T_DATA = TYPEW'(2),
    parameter logic [TYPEW-1:0] T_TAIL = TYPEW'(3),
    localparam int             VCW    = (VCN > 1) ? $clog2(VCN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    enable,
    input  logic [LENW-1:0]         cfg_len,
    input  logic [GAPW-1:0]         cfg_gap,
    input  logic [CNTW-1:0]         cfg_npkt,
    input  logic [PAYW-1:0]         cfg_dst,
    input  logic [VCW-1:0]          cfg_vch,
    noc_traffic_gen_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNTW-1:0]         pkt_cnt,
    output logic [CNTW-1:0]         flit_cnt
);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0]     SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0]     TAPS     = 32'h8020_0003;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_DATA, S_TAIL, S_GAP, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [LENW-1:0]   len_reg, len_next;
    logic [GAPW-1:0]   gap_reg, gap_next;
    logic [PAYW-1:0]   dst_reg, dst_next;
    logic [VCW-1:0]    vch_reg, vch_next;
    logic [LENW-1:0]   rem_reg, rem_next;
    logic [GAPW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [31:0]       lfsr_reg, lfsr_next;
    logic [CNTW-1:0]   pkt_cnt_reg, pkt_cnt_next;
    logic [CNTW-1:0]   flit_cnt_reg, flit_cnt_next;

    logic [31:0]       lfsr_adv;
    logic [PAYW-1:0]   lfsr_pay;
    logic              flit_state;
    logic              accept;
    logic              load_cfg;

    // One LFSR step: shift right, fold the dropped bit back in at the taps.
    generate
        for (genvar gi = 0; gi < 31; gi++) begin : g_lfsr
            assign lfsr_adv[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
        end
    endgenerate
    assign lfsr_adv[31] = TAPS[31] & lfsr_reg[0];

    generate
        if (PAYW > 32) begin : g_pay_wide
            assign lfsr_pay = {{(PAYW-32){1'b0}}, lfsr_reg};
        end else begin : g_pay_narrow
            assign lfsr_pay = lfsr_reg[PAYW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            gap_reg      <= '0;
            dst_reg      <= '0;
            vch_reg      <= '0;
            rem_reg      <= '0;
            gap_cnt_reg  <= '0;
            lfsr_reg     <= SEED_EFF;
            pkt_cnt_reg  <= '0;
            flit_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            gap_reg      <= gap_next;
            dst_reg      <= dst_next;
            vch_reg      <= vch_next;
            rem_reg      <= rem_next;
            gap_cnt_reg  <= gap_cnt_next;
            lfsr_reg     <= lfsr_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            flit_cnt_reg <= flit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        gap_next      = gap_reg;
        dst_next      = dst_reg;
        vch_next      = vch_reg;
        rem_next      = rem_reg;
        gap_cnt_next  = gap_cnt_reg;
        lfsr_next     = lfsr_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        flit_cnt_next = flit_cnt_reg;
        load_cfg      = 1'b0;

        flit_state = (state_reg == S_HEAD) || (state_reg == S_DATA) ||
                     (state_reg == S_TAIL);
        // Only the ready bit of the packet's own VC matters.
        accept     = flit_state && bus.ordy[vch_reg];

        bus.ovalid = flit_state;
        bus.ovch   = vch_reg;
        bus.odata  = {T_NONE, {PAYW{1'b0}}};
        busy       = flit_state || (state_reg == S_GAP);
        done       = (state_reg == S_DONE);

        if (accept) begin
            flit_cnt_next = flit_cnt_reg + CNT_ONE;
        end

        case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_HEAD;
                    load_cfg   = 1'b1;
                end
            end
            S_HEAD: begin
                bus.odata = {T_HEAD, dst_reg};
                if (accept) begin
                    rem_next   = len_reg;
                    state_next = (len_reg != '0) ? S_DATA : S_TAIL;
                end
            end
            S_DATA: begin
                bus.odata = {T_DATA, lfsr_pay};
                if (accept) begin
                    lfsr_next = lfsr_adv;
                    rem_next  = rem_reg - 1'b1;
                    if (rem_reg == LENW'(1)) begin
                        state_next = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                bus.odata = {T_TAIL, lfsr_pay};
                if (accept) begin
                    lfsr_next    = lfsr_adv;
                    pkt_cnt_next = pkt_cnt_reg + CNT_ONE;
                    if ((cfg_npkt != '0) && (pkt_cnt_reg + CNT_ONE == cfg_npkt)) begin
                        state_next = S_DONE;
                    end else if (gap_reg != '0) begin
                        state_next   = S_GAP;
                        gap_cnt_next = gap_reg;
                    end else if (enable) begin
                        state_next = S_HEAD;
                        load_cfg   = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // gap_cnt holds the idle cycles still to spend, this one included.
                if (gap_cnt_reg <= GAPW'(1)) begin
                    if (enable) begin
                        state_next = S_HEAD;
                        load_cfg   = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_next   = S_IDLE;
                    pkt_cnt_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Packet parameters are frozen from HEAD entry to TAIL.
        if (load_cfg) begin
            len_next = cfg_len;
            gap_next = cfg_gap;
            dst_next = cfg_dst;
            vch_next = cfg_vch;
        end
    end

    assign pkt_cnt  = pkt_cnt_reg;
    assign flit_cnt = flit_cnt_reg;

endmodule

// File: tb/tb_noc_traffic_gen.sv
module tb_noc_traffic_gen;
    localparam int PAYW = 32, TYPEW = 2, VCN = 4, LENW = 8, GAPW = 8, CNTW = 32;
    localparam logic [1:0] TN = 2'd0, TH = 2'd1, TD = 2'd2, TT = 2'd3;

    logic              clk = 1'b0;
    logic              rst_;
    logic              enable;
    logic [LENW-1:0]   cfg_len;
    logic [GAPW-1:0]   cfg_gap;
    logic [CNTW-1:0]   cfg_npkt;
    logic [PAYW-1:0]   cfg_dst;
    logic [1:0]        cfg_vch;
    logic              busy, done;
    logic [CNTW-1:0]   pkt_cnt, flit_cnt;

    noc_traffic_gen_if #(.PAYW(PAYW), .TYPEW(TYPEW), .VCN(VCN)) bus ();

    noc_traffic_gen #(
        .PAYW(PAYW), .TYPEW(TYPEW), .VCN(VCN), .LENW(LENW), .GAPW(GAPW),
        .CNTW(CNTW), .SEED(32'h1),
        .T_NONE(TN), .T_HEAD(TH), .T_DATA(TD), .T_TAIL(TT)
    ) dut (
        .clk(clk), .rst_(rst_), .enable(enable),
        .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_npkt(cfg_npkt),
        .cfg_dst(cfg_dst), .cfg_vch(cfg_vch),
        .bus(bus),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: position within the packet plus a software LFSR.
    logic [31:0] m_lfsr;
    logic [31:0] m_dst;
    logic [1:0]  m_vch;
    int          m_len, m_pos;
    int unsigned m_flits, m_pkts;
    int          head_cyc[$];

    // Protocol hold tracking.
    logic        stall_pend = 1'b0;
    logic [33:0] h_data;
    logic [1:0]  h_vch;

    typedef struct {
        int          len;
        int          gap;
        int          npkt;
        logic [31:0] dst;
        int          vch;
        int          exp_busy;
        int          exp_flits;
        int          exp_period;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] poly;
        poly = 32'h8020_0003;
        return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = 32'h1;
        m_pos   = 0;
        m_flits = 0;
        m_pkts  = 0;
    endtask

    // Runs at the falling edge: predicts what the next rising edge transfers.
    task automatic monitor();
        logic [33:0] ef;
        if (stall_pend) begin
            chk("hold_valid", 64'(bus.ovalid), 64'(1));
            chk("hold_data", 64'(bus.odata), 64'(h_data));
            chk("hold_vch", 64'(bus.ovch), 64'(h_vch));
        end
        stall_pend = rst_ && bus.ovalid && !bus.ordy[bus.ovch];
        h_data = bus.odata;
        h_vch  = bus.ovch;
        if (rst_ && bus.ovalid && bus.ordy[bus.ovch]) begin
            if (m_pos == 0)          ef = {TH, m_dst};
            else if (m_pos <= m_len) ef = {TD, m_lfsr};
            else                     ef = {TT, m_lfsr};
            chk("flit", 64'(bus.odata), 64'(ef));
            chk("flit_vch", 64'(bus.ovch), 64'(m_vch));
            m_flits++;
            if (m_pos == 0) head_cyc.push_back(cyc);
            else            m_lfsr = lfsr_step(m_lfsr);
            if (m_pos == m_len + 1) begin
                m_pos = 0;
                m_pkts++;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_   = 1'b0;
        enable = 1'b0;
        model_reset();
        tick();
        tick();
        rst_ = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ovalid"}, 64'(bus.ovalid), 64'(0));
        chk({tag, "_odata"}, 64'(bus.odata), 64'(0));
        chk({tag, "_ovch"}, 64'(bus.ovch), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(0));
        chk({tag, "_flit_cnt"}, 64'(flit_cnt), 64'(0));
    endtask

    task automatic set_cfg(input int len, input int gap, input int npkt,
                           input logic [31:0] dst, input int vch);
        cfg_len  = LENW'(len);
        cfg_gap  = GAPW'(gap);
        cfg_npkt = CNTW'(npkt);
        cfg_dst  = dst;
        cfg_vch  = 2'(vch);
        m_len    = len;
        m_dst    = dst;
        m_vch    = 2'(vch);
    endtask

    // Drain with full ready, then require a packet boundary and matching counters.
    task automatic wait_idle(input string tag);
        bus.ordy = 4'hF;
        for (int k = 0; k < 300 && busy; k++) tick();
        chk({tag, "_idle"}, 64'(busy), 64'(0));
        chk({tag, "_pkt_boundary"}, 64'(m_pos), 64'(0));
        chk({tag, "_flit_cnt"}, 64'(flit_cnt), 64'(m_flits));
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkts));
    endtask

    initial begin
        int          nb;
        logic [9:0]  pat;

        rst_ = 1'b0; enable = 1'b0; bus.ordy = 4'hF;
        set_cfg(0, 0, 0, 32'h0, 0);
        model_reset();

        //             len gap npkt dst           vch busy flits period
        tbl[0] = '{4, 7, 3, 32'h9,        0, 32, 18, 13};
        tbl[1] = '{0, 0, 5, 32'h1234,     1, 10, 10, 2};
        tbl[2] = '{1, 2, 2, 32'hDEADBEEF, 3, 8,  6,  5};
        tbl[3] = '{3, 0, 1, 32'h0,        2, 5,  5,  5};
        tbl[4] = '{0, 1, 4, 32'hFFFFFFFF, 1, 11, 8,  3};

        // Table-driven packet-budget runs at full rate.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            check_reset_state("reset");
            set_cfg(tbl[i].len, tbl[i].gap, tbl[i].npkt, tbl[i].dst, tbl[i].vch);
            bus.ordy = 4'hF;
            head_cyc.delete();
            enable = 1'b1;
            tick();
            chk("head_latency_valid", 64'(bus.ovalid), 64'(1));
            chk("head_latency_type", 64'(bus.odata[33:32]), 64'(TH));
            nb = 0;
            for (int k = 0; k < 400 && !done; k++) begin
                if (busy) nb++;
                tick();
            end
            chk("done_set", 64'(done), 64'(1));
            chk("busy_cycles", 64'(nb), 64'(tbl[i].exp_busy));
            chk("flit_cnt", 64'(flit_cnt), 64'(tbl[i].exp_flits));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(tbl[i].npkt));
            chk("done_no_valid", 64'(bus.ovalid), 64'(0));
            chk("head_count", 64'(head_cyc.size()), 64'(tbl[i].npkt));
            for (int j = 1; j < head_cyc.size(); j++)
                chk("inject_period", 64'(head_cyc[j] - head_cyc[j-1]), 64'(tbl[i].exp_period));
            tick();
            chk("done_held", 64'(done), 64'(1));
            enable = 1'b0;
            tick();
            chk("done_cleared", 64'(done), 64'(0));
            chk("pkt_cnt_cleared", 64'(pkt_cnt), 64'(0));
        end

        // Back-to-back zero-length packets: valid and busy every cycle.
        do_reset();
        set_cfg(0, 0, 0, 32'h77, 3);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk("b2b_valid", 64'(bus.ovalid), 64'(1));
            chk("b2b_busy", 64'(busy), 64'(1));
            tick();
        end
        enable = 1'b0;
        wait_idle("b2b");

        // Stalls on VC 2 with the other VCs' ready bits inverted.
        do_reset();
        set_cfg(4, 0, 1, 32'h55, 2);
        bus.ordy = 4'hF;
        enable = 1'b1;
        tick();
        tick();
        pat = 10'b11_0010_1001;
        for (int k = 0; k < 10; k++) begin
            bus.ordy = pat[k] ? 4'b0100 : 4'b1011;
            tick();
        end
        bus.ordy = 4'hF;
        for (int k = 0; k < 50 && !done; k++) tick();
        chk("stall_done", 64'(done), 64'(1));
        chk("stall_flit_cnt", 64'(flit_cnt), 64'(6));
        chk("stall_pkt_cnt", 64'(pkt_cnt), 64'(1));
        enable = 1'b0;
        tick();

        // enable dropped on the second DATA flit: packet still completes.
        do_reset();
        set_cfg(4, 0, 0, 32'hA5, 1);
        bus.ordy = 4'hF;
        enable = 1'b1;
        tick(); tick(); tick();
        chk("drop_on_data", 64'(bus.odata[33:32]), 64'(TD));
        enable = 1'b0;
        wait_idle("drop");
        chk("drop_flits", 64'(flit_cnt), 64'(6));
        chk("drop_pkts", 64'(pkt_cnt), 64'(1));
        for (int k = 0; k < 3; k++) begin
            chk("drop_stay_idle", 64'(bus.ovalid), 64'(0));
            tick();
        end

        // Reset in the middle of DATA, then restart from SEED.
        do_reset();
        set_cfg(4, 0, 0, 32'hC0FFEE, 0);
        bus.ordy = 4'hF;
        enable = 1'b1;
        tick(); tick(); tick();
        rst_ = 1'b0;
        model_reset();
        tick();
        check_reset_state("midreset");
        rst_ = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        enable = 1'b0;
        wait_idle("midreset_restart");

        // Randomized segments: random config, random ready, random enable.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 4), 0, $urandom, $urandom_range(0, 3));
            enable = 1'b1;
            for (int k = 0, n = $urandom_range(5, 40); k < n; k++) begin
                bus.ordy = 4'($urandom_range(0, 15));
                enable   = ($urandom_range(0, 9) != 0);
                tick();
            end
            enable = 1'b0;
            wait_idle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
